// File: rtl/l2_l1_pkg.sv
// Shared widths, FSM state type and address helper for the L2 -> L1-I refill path.
package l2_l1_pkg;

  localparam int LINE_W = 512;
  localparam int WORD_W = 32;
  localparam int IDX_W  = 6;
  localparam int OFS_W  = 6;
  localparam int BASE_W = 32 - OFS_W;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    DELIVER = 2'd3
  } refill_state_e;

  // Word-aligned address of one beat within a 64-byte line.
  function automatic logic [31:0] beatAddr(input logic [BASE_W-1:0] base,
                                           input logic [CNT_W-1:0]  beat);
    return {base, beat, 2'b00};
  endfunction

endpackage

// File: rtl/line_assembler.sv
// Line buffer that collects refill words into one cache line, one beat per write.
module line_assembler
  import l2_l1_pkg::*;
#(
  parameter int BEATS = 16
) (
  input  logic                     i_clk,
  input  logic                     i_clr,
  input  logic [WORD_W-1:0]        i_word,
  input  logic [$clog2(BEATS)-1:0] i_beat,
  input  logic                     i_we,
  output logic [LINE_W-1:0]        o_line
);

  localparam int BEAT_W = $clog2(BEATS);

  logic [LINE_W-1:0] r_line;

  // Contents persist between refills; only the addressed word is replaced.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_line <= '0;
    end else begin
      for (int k = 0; k < BEATS; k++) begin
        if (i_we && (i_beat == BEAT_W'(k))) begin
          r_line[k*WORD_W +: WORD_W] <= i_word;
        end
      end
    end
  end

  assign o_line = r_line;

endmodule

// File: rtl/l2_l1_refill_ctrl.sv
// L1-I miss refill controller: fetches a 64-byte line as 16 single-outstanding word reads.
module l2_l1_refill_ctrl
  import l2_l1_pkg::*;
#(
  parameter int BEATS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_valid,
  input  logic [31:0]       miss_addr,
  output logic              miss_ready,
  output logic              mem_req_valid,
  output logic [31:0]       mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic [LINE_W-1:0] read_data_L2_L1,
  output logic              refill,
  output logic [IDX_W-1:0]  refill_index,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  refill_state_e     r_state;
  refill_state_e     w_nextState;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_nextCnt;
  logic [BASE_W-1:0] r_lineBase;
  logic [BASE_W-1:0] w_nextBase;
  logic              w_beatWe;
  logic [OFS_W-1:0]  w_unusedOfs;

  assign w_unusedOfs = miss_addr[OFS_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_lineBase <= '0;
    end else begin
      r_state    <= w_nextState;
      r_cnt      <= w_nextCnt;
      r_lineBase <= w_nextBase;
    end
  end

  // Read data only counts while a request is outstanding (WAIT); elsewhere it is dropped.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_nextBase  = r_lineBase;
    w_beatWe    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (miss_valid) begin
          w_nextState = ISSUE;
          w_nextCnt   = '0;
          w_nextBase  = miss_addr[31:OFS_W];
        end
      end
      ISSUE: begin
        if (mem_req_ready) begin
          w_nextState = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          w_beatWe = 1'b1;
          if (r_cnt == LAST_BEAT) begin
            w_nextState = DELIVER;
          end else begin
            w_nextCnt   = r_cnt + CNT_W'(1);
            w_nextState = ISSUE;
          end
        end
      end
      DELIVER: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  line_assembler #(
    .BEATS (BEATS)
  ) u_lineAssembler (
    .i_clk  (clk),
    .i_clr  (rst),
    .i_word (mem_rdata),
    .i_beat (r_cnt),
    .i_we   (w_beatWe),
    .o_line (read_data_L2_L1)
  );

  assign miss_ready    = (r_state == IDLE);
  assign busy          = (r_state != IDLE);
  assign mem_req_valid = (r_state == ISSUE);
  assign mem_req_addr  = beatAddr(r_lineBase, r_cnt);
  assign refill        = (r_state == DELIVER);
  assign refill_index  = r_lineBase[IDX_W-1:0];

endmodule

// File: tb/tb_l2_l1_refill_ctrl.sv
// Scoreboard bench for l2_l1_refill_ctrl with a single-outstanding memory responder model.
module tb_l2_l1_refill_ctrl;
  import l2_l1_pkg::*;

  typedef struct {
    logic [IDX_W-1:0]  index;
    logic [LINE_W-1:0] line;
    int                acceptCycle;
    int                latency;
  } expect_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              miss_valid;
  logic [31:0]       miss_addr;
  logic              miss_ready;
  logic              mem_req_valid;
  logic [31:0]       mem_req_addr;
  logic              mem_req_ready;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;
  logic [LINE_W-1:0] read_data_L2_L1;
  logic              refill;
  logic [IDX_W-1:0]  refill_index;
  logic              busy;

  always #5 clk = ~clk;

  l2_l1_refill_ctrl #(.BEATS(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .miss_valid      (miss_valid),
    .miss_addr       (miss_addr),
    .miss_ready      (miss_ready),
    .mem_req_valid   (mem_req_valid),
    .mem_req_addr    (mem_req_addr),
    .mem_req_ready   (mem_req_ready),
    .mem_rvalid      (mem_rvalid),
    .mem_rdata       (mem_rdata),
    .read_data_L2_L1 (read_data_L2_L1),
    .refill          (refill),
    .refill_index    (refill_index),
    .busy            (busy)
  );

  int          checkCount = 0;
  int          errorCount = 0;
  int          cycle = 0;
  expect_t     sb[$];
  logic [31:0] reqQ[$];
  int          acceptLog[$];
  int          refillLog[$];
  logic [31:0] dataXor = '0;
  int          stallBeat = 5;
  int          stallCfg = 0;
  int          stallLeft = 0;
  bit          pendingResp = 0;
  bit          spurious = 0;
  bit          resetReq = 1;
  logic [31:0] respAddr = '0;
  logic [25:0] curBase = '0;
  int          tbBeat = 0;
  int          lastHandshakeBeat = -1;

  task automatic checkOutput(input string tag, input logic [LINE_W-1:0] observed,
                             input logic [LINE_W-1:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [LINE_W-1:0] buildLine(input logic [31:0] addr, input logic [31:0] x);
    logic [LINE_W-1:0] l;
    l = '0;
    for (int k = 0; k < 16; k++) l[k*32 +: 32] = {addr[31:6], 4'(k), 2'b00} ^ x;
    return l;
  endfunction

  // One clock of stimulus: monitor refill, play the memory, present queued misses.
  task automatic applyStimulus();
    expect_t e;
    @(negedge clk);
    cycle++;
    if (refill) begin
      refillLog.push_back(cycle);
      if (sb.size() == 0) begin
        checkOutput("unexpectedRefill", 1, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("refillIndex", refill_index, e.index);
        checkOutput("refillLine", read_data_L2_L1, e.line);
        checkOutput("refillLatency", cycle - e.acceptCycle, e.latency);
      end
    end
    mem_req_ready = 1'b0;
    mem_rvalid    = 1'b0;
    mem_rdata     = '0;
    if (spurious) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEADBEEF;
      spurious   = 0;
    end else if (pendingResp) begin
      checkOutput("reqValidInWait", mem_req_valid, 0);
      mem_rvalid  = 1'b1;
      mem_rdata   = respAddr ^ dataXor;
      pendingResp = 0;
    end else if (mem_req_valid) begin
      if (stallLeft > 0 && tbBeat == stallBeat) begin
        checkOutput("stallAddr", mem_req_addr, {curBase, 4'(stallBeat), 2'b00});
        stallLeft--;
      end else begin
        checkOutput("reqAddr", mem_req_addr, {curBase, 4'(tbBeat), 2'b00});
        mem_req_ready     = 1'b1;
        pendingResp       = 1;
        respAddr          = mem_req_addr;
        lastHandshakeBeat = tbBeat;
        tbBeat++;
      end
    end
    if (resetReq) begin
      pendingResp = 0;
      sb.delete();
    end
    miss_valid = 1'b0;
    miss_addr  = '0;
    if (!resetReq && reqQ.size() > 0) begin
      miss_valid = 1'b1;
      miss_addr  = reqQ[0];
      if (busy) checkOutput("missReadyBusy", miss_ready, 0);
      if (miss_ready) begin
        e.index       = reqQ[0][11:6];
        e.line        = buildLine(reqQ[0], dataXor);
        e.acceptCycle = cycle;
        e.latency     = 33 + stallCfg;
        sb.push_back(e);
        acceptLog.push_back(cycle);
        curBase           = reqQ[0][31:6];
        tbBeat            = 0;
        lastHandshakeBeat = -1;
        stallLeft         = stallCfg;
        void'(reqQ.pop_front());
      end
    end
    rst = resetReq;
  endtask

  task automatic runUntilDone(input int maxCycles);
    int n;
    n = 0;
    while ((reqQ.size() > 0 || sb.size() > 0) && n < maxCycles) begin
      applyStimulus();
      n++;
    end
    if (reqQ.size() > 0 || sb.size() > 0) begin
      checkOutput("timeout", 1, 0);
      reqQ.delete();
      sb.delete();
    end
    repeat (2) applyStimulus();
  endtask

  initial begin
    int gap;
    int refillsBefore;
    int n;
    rst = 1'b1;
    miss_valid = 1'b0;
    miss_addr = '0;
    mem_req_ready = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;

    repeat (3) applyStimulus();
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstReqValid", mem_req_valid, 0);
    checkOutput("rstRefill", refill, 0);
    checkOutput("rstLine", read_data_L2_L1, 0);
    resetReq = 0;
    applyStimulus();
    checkOutput("missReadyAfterRst", miss_ready, 1);

    $display("[TB] zero-wait refill");
    reqQ.push_back(32'h0000_1A40);
    runUntilDone(200);
    checkOutput("zwIndex", refill_index, 6'h29);
    checkOutput("zwHold", read_data_L2_L1, buildLine(32'h0000_1A40, 32'h0));

    $display("[TB] backpressure on beat 5");
    dataXor  = 32'hA5A5_0000;
    stallCfg = 3;
    reqQ.push_back(32'h0000_1A40);
    runUntilDone(200);
    stallCfg = 0;

    $display("[TB] spurious rvalid in IDLE");
    spurious = 1;
    refillsBefore = refillLog.size();
    repeat (3) applyStimulus();
    checkOutput("spurLine", read_data_L2_L1, buildLine(32'h0000_1A40, 32'hA5A5_0000));
    checkOutput("spurBusy", busy, 0);
    checkOutput("spurNoRefill", refillLog.size(), refillsBefore);

    $display("[TB] back-to-back misses");
    dataXor = 32'h1111_1111;
    acceptLog.delete();
    refillLog.delete();
    reqQ.push_back(32'h0000_5000);
    reqQ.push_back(32'h0000_5FC0);
    runUntilDone(400);
    checkOutput("b2bRefills", refillLog.size(), 2);
    gap = (acceptLog.size() >= 2 && refillLog.size() >= 1) ? acceptLog[1] - refillLog[0] : -1;
    checkOutput("b2bGap", gap, 1);

    $display("[TB] miss while busy");
    dataXor = 32'h0F0F_3C3C;
    acceptLog.delete();
    refillLog.delete();
    reqQ.push_back(32'h0000_3C80);
    repeat (5) applyStimulus();
    reqQ.push_back(32'h0000_7100);
    runUntilDone(400);
    checkOutput("busyRefills", refillLog.size(), 2);
    gap = (acceptLog.size() >= 2 && refillLog.size() >= 1) ? acceptLog[1] - refillLog[0] : -1;
    checkOutput("busyGap", gap, 1);

    $display("[TB] reset mid-transfer");
    dataXor = 32'h0;
    reqQ.push_back(32'h0000_2A80);
    n = 0;
    while (lastHandshakeBeat != 7 && n < 100) begin
      applyStimulus();
      n++;
    end
    checkOutput("reachBeat7", lastHandshakeBeat, 7);
    refillsBefore = refillLog.size();
    resetReq = 1;
    applyStimulus();
    resetReq = 0;
    spurious = 1;
    applyStimulus();
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortMissReady", miss_ready, 1);
    checkOutput("abortLine", read_data_L2_L1, 0);
    repeat (40) applyStimulus();
    checkOutput("abortNoRefill", refillLog.size(), refillsBefore);
    checkOutput("abortLineStale", read_data_L2_L1, 0);

    $display("[TB] refill after abort");
    dataXor = 32'h8000_0001;
    reqQ.push_back(32'hFFFF_FFC0);
    runUntilDone(200);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/l2_l1_refill_ctrl.md
L2_L1_REFILL_CTRL -- requirements
Module: l2_l1_refill_ctrl

Interface
REQ-001 The block SHALL have the ports `clk`, input, 1 bit: single clock; all logic is on the rising edge.
REQ-002 The block SHALL have the port `rst`, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have the port `miss_valid`, input, 1 bit: L1-I miss request is valid.
REQ-004 The block SHALL have the port `miss_addr`, input, 32 bits: miss byte address; `[11:6]` = index, `[5:0]` = offset (ignored).
REQ-005 The block SHALL have the port `miss_ready`, output, 1 bit: the block accepts the request this cycle.
REQ-006 The block SHALL have the port `mem_req_valid`, output, 1 bit: word read request to backing memory.
REQ-007 The block SHALL have the port `mem_req_addr`, output, 32 bits: word-aligned read address.
REQ-008 The block SHALL have the port `mem_req_ready`, input, 1 bit: memory accepts the request.
REQ-009 The block SHALL have the port `mem_rvalid`, input, 1 bit: read data is valid.
REQ-010 The block SHALL have the port `mem_rdata`, input, 32 bits: read data word.
REQ-011 The block SHALL have the port `read_data_L2_L1`, output, 512 bits: assembled line to the L1-I data array.
REQ-012 The block SHALL have the port `refill`, output, 1 bit: one-cycle write strobe to the L1-I data and tag arrays.
REQ-013 The block SHALL have the port `refill_index`, output, 6 bits: set index for the refill.
REQ-014 The block SHALL have the port `busy`, output, 1 bit: high in every state except IDLE.
REQ-015 The block SHALL have the parameter `BEATS`, default 16: words per 64-byte line (fixed at 16; other values are out of scope).

Function
REQ-016 The FSM SHALL have the states IDLE, ISSUE, WAIT, DELIVER, encoded in 2 bits.
REQ-017 `miss_ready` SHALL be 1 only in IDLE; a request is accepted when `miss_valid` and `miss_ready` are both 1.
REQ-018 On accept, the block SHALL latch `line_base = miss_addr[31:6]`, clear beat counter `cnt[3:0]` to 0 and go to ISSUE.
REQ-019 In ISSUE, `mem_req_valid` SHALL be 1 and `mem_req_addr` SHALL equal `{line_base, cnt, 2'b00}`; both SHALL be held stable until `mem_req_ready`=1, then the FSM goes to WAIT.
REQ-020 Only one memory request SHALL be outstanding; `mem_req_valid` SHALL be 0 outside ISSUE.
REQ-021 In WAIT, on `mem_rvalid`=1 the block SHALL write `mem_rdata` to line buffer bits `[32*cnt +: 32]`.
REQ-022 On that WAIT beat, if `cnt`=15 the FSM SHALL go to DELIVER; otherwise `cnt` SHALL increment by 1 and the FSM SHALL go back to ISSUE.
REQ-023 `mem_rvalid` SHALL be ignored in IDLE, ISSUE and DELIVER.
REQ-024 In DELIVER, `refill` SHALL be 1 for exactly one cycle, and `read_data_L2_L1` and `refill_index` (= `line_base[5:0]`) SHALL be valid in that cycle; the next state SHALL be IDLE.
REQ-025 `read_data_L2_L1` SHALL hold the last line after DELIVER and SHALL be overwritten beat by beat during the next refill.
REQ-026 A new request SHALL NOT be accepted in the DELIVER cycle; the earliest accept is the cycle after DELIVER.
REQ-027 With zero-wait memory (`mem_req_ready` and `mem_rvalid` each 1 the cycle after being awaited), accept-to-`refill` latency SHALL be 33 cycles: 16×(ISSUE+WAIT) + DELIVER.
REQ-028 `cnt` SHALL wrap 15→0 only through IDLE re-entry; no other wrap is permitted.

Reset
REQ-029 While `rst`=1 at a rising edge, the FSM SHALL go to IDLE and `cnt`, `line_base`, the line buffer, `refill`, `mem_req_valid` and `busy` SHALL be cleared to 0.
REQ-030 Reset SHALL abort any transfer in progress; a `mem_rvalid` arriving after reset SHALL be discarded, and `refill` SHALL NOT be generated.
REQ-031 `miss_ready` SHALL be 1 in the first cycle after `rst` deasserts.

Structure
REQ-032 A shared package `l2_l1_pkg` SHALL hold `LINE_W`=512, `WORD_W`=32, `IDX_W`=6, `OFS_W`=6, and the FSM state typedef.
REQ-033 The FSM and counter SHALL stay in `l2_l1_refill_ctrl`.
REQ-034 The line buffer SHALL be a sub-module `line_assembler` (inputs: word, beat index, write enable, clear; output: 512-bit line).

Verification
REQ-035 Zero-wait refill: request `miss_addr`=0x0000_1A40 with `mem_rdata`=addr → `refill` at cycle 33, `refill_index`=0x29, word k = 0x1A40+4k.
REQ-036 Memory backpressure: `mem_req_ready` low for 3 cycles on beat 5 → `mem_req_addr` stays 0x…54 throughout, the line is correct, latency is 36 cycles.
REQ-037 Back-to-back misses: `miss_valid` held high for indices 0x00 then 0x3F → second accept in the cycle after the first `refill`, and exactly two `refill` pulses.
REQ-038 Busy rejection: second `miss_valid` while `busy` → `miss_ready`=0, and that request is not accepted until IDLE.
REQ-039 Reset mid-transfer: `rst` at beat 7 → IDLE next cycle, no `refill`, and a stale `mem_rvalid` is ignored.
REQ-040 Spurious data: `mem_rvalid`=1 in IDLE with 0xDEADBEEF → line buffer and `cnt` unchanged.
